interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Sequences the 6502 reset, NMI, IRQ and BRK entry flows. It sits beside `instruction_decode` and takes over the address bus, R/W and stack-pointer controls for the seven-cycle interrupt entry. It arbitrates pending requests at opcode-fetch boundaries, pushes PCH/PCL/P, and fetches the vector into the PC. While `busy` is high, the decoder holds.

## Interface
Parameters:
- `STACK_PAGE`, default 8'h01: high address byte for push cycles.

Ports:
- `clk`  in  1  system clock.
- `res`  in  1  reset; asynchronous, active-low.
- `rdy`  in  1  ready; low stalls read cycles only.
- `nmi`  in  1  active-low NMI, falling-edge sensitive, synchronous to `clk`.
- `irq`  in  1  active-low IRQ, level sensitive.
- `i_flag`  in  1  status I bit.
- `sync`  in  1  decoder is in its opcode-fetch cycle.
- `brk_op`  in  1  opcode on the data bus during `sync` is BRK (8'h00).
- `sp`  in  8  current stack pointer.
- `busy`  out  1  sequence active; the decoder must hold.
- `addr_override`  out  1  the address mux selects `addr`.
- `addr`  out  16  bus address when overriding.
- `rw`  out  1  1 = read, 0 = write.
- `push_sel`  out  2  data-out source: 00 none, 01 PCH, 10 PCL, 11 P.
- `b_flag`  out  1  B bit value for the pushed P.
- `sp_dec`  out  1  decrement SP this cycle.
- `pcl_load`, `pch_load`  out  1 each  load PC byte from the data bus.
- `set_i`  out  1  set the I flag.
- `pc_inc_inhibit`  out  1  suppress PC increment in the `sync` cycle.
- `ack`  out  1  one-cycle pulse in the final vector cycle.

## Operation
- States: S_RESET_HOLD, S_IDLE, S_DUMMY, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI.
- **Request latching.**
  - The NMI edge detector sets `nmi_pending` when `nmi` is sampled 1 and then 0.
  - `irq_req` = !irq && !i_flag, sampled combinationally.
- **Arbitration.** Evaluated in S_IDLE only when `sync`=1. Priority: NMI > BRK > IRQ.
  - The winner is latched in `kind`: RES, NMI, BRK or IRQ.
  - Next state is S_DUMMY.
  - For NMI and IRQ, `pc_inc_inhibit`=1 in that cycle.
- **S_DUMMY.** `addr_override`=0 and `rw`=1 (the bus reads at PC).
- **Push states.**
  - `addr` = {STACK_PAGE, sp}; `sp_dec`=1; `push_sel` = PCH, PCL, then P.
  - `rw`=0, except for kind RES, where `rw`=1 (suppressed writes).
  - `b_flag` = (kind==BRK).
- **Vector states.**
  - `addr` = FFFA (NMI), FFFC (RES), or FFFE (IRQ/BRK); S_VEC_HI uses `addr`+1.
  - S_VEC_LO: `pcl_load`=1, `set_i`=1.
  - S_VEC_HI: `pch_load`=1, `ack`=1, then go to S_IDLE.
- **NMI clear.** `nmi_pending` clears in S_VEC_LO when the vector used is FFFA.
- **Reset.**
  - While `res`=0: state S_RESET_HOLD, `nmi_pending` cleared.
  - On the first clock with `res`=1: kind=RES, go to S_DUMMY, then the full sequence without writes.

## Timing
- **Reset values (async).**
  - `busy`=1 (held through S_RESET_HOLD).
  - `addr_override`=0, `addr`=0, `rw`=1, `push_sel`=00.
  - All pulse outputs 0.
  - State S_RESET_HOLD.
- **Latency.** `sync` cycle T0 is followed by six cycles T1–T6; the new PC is valid after T6.
  - `busy` is 1 from T1 through T6; 0 in S_IDLE.
- **rdy.**
  - `rdy`=0 freezes state in read cycles: S_DUMMY, S_VEC_*, and all RES push cycles.
  - Write cycles advance regardless of `rdy`.
- **Simultaneous events.** NMI and IRQ pending at the same `sync`: NMI is taken, and IRQ is re-evaluated at the next `sync`.
- **Masked IRQ.** `irq` is ignored when `i_flag`=1. IRQ deasserted before a `sync`: nothing is taken.
- **Reset mid-sequence.** Asynchronous abort to S_RESET_HOLD; nothing further is pushed.
- **SP.** 8-bit wrap is handled by the SP register; `addr` low byte is always the `sp` input.

## Configuration
- `INT_NMI_HIJACK_EN` defined:
  - An NMI edge detected during S_DUMMY through S_PUSH_P of an IRQ/BRK sequence redirects the vector to FFFA.
  - The pushed B still reflects the original kind.
  - `nmi_pending` clears in S_VEC_LO.
- Undefined:
  - The vector is fixed at arbitration.
  - The NMI stays pending and is taken at the next `sync`.

## Structure
- Shared package/header `inc/interrupt.vh`:
  - state encodings;
  - kind codes (RES/NMI/BRK/IRQ);
  - vector constants 16'hFFFA/16'hFFFC/16'hFFFE;
  - `push_sel` codes.
- Sub-module `nmi_edge_detect`: registers `nmi`, produces `nmi_pending`, with set-on-falling-edge and clear input.

## Test plan
- Release `res`, `rdy`=1, sp=8'hFD:
  - `rw` stays 1 for all cycles; three `sp_dec` pulses.
  - `addr` FFFC then FFFD; `ack` 6 cycles after release of S_RESET_HOLD.
- `irq`=0, `i_flag`=0, `sync` pulse, sp=8'hF0:
  - writes at 01F0/01EF/01EE with `push_sel` 01/10/11, `b_flag`=0.
  - vector FFFE/FFFF; `set_i`=1 in S_VEC_LO.
- `brk_op`=1 at `sync` with `irq`=0:
  - BRK wins; `b_flag`=1; `pc_inc_inhibit`=0; vector FFFE.
- `nmi` 1→0 and `irq`=0 at the same `sync`:
  - NMI taken with vector FFFA; IRQ taken at the following `sync`.
- NMI edge during S_PUSH_PCL of an IRQ:
  - with `INT_NMI_HIJACK_EN`: vector FFFA and pending cleared.
  - without: vector FFFE and NMI serviced next.
- `rdy`=0 for 3 cycles in S_VEC_LO: state and `addr` held, `pcl_load` held. Assert `res`=0 in S_PUSH_P: `rw`=1 immediately and state S_RESET_HOLD.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer_pkg
// Shared types and constants for the 6502 interrupt entry sequencer:
//   state encodings, request kinds, vector addresses and push_sel codes,
//   plus a helper that maps a request kind to its vector address.
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_IDLE,
    S_DUMMY,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_P,
    S_VEC_LO,
    S_VEC_HI
  } state_e;

  typedef enum logic [1:0] {
    K_RES,
    K_NMI,
    K_BRK,
    K_IRQ
  } kind_e;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  localparam logic [1:0] PSEL_NONE = 2'b00;
  localparam logic [1:0] PSEL_PCH  = 2'b01;
  localparam logic [1:0] PSEL_PCL  = 2'b10;
  localparam logic [1:0] PSEL_P    = 2'b11;

  function automatic logic [15:0] kind_vec(input kind_e k);
    case (k)
      K_NMI:   return VEC_NMI;
      K_RES:   return VEC_RES;
      default: return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// nmi_edge_detect
// Registers the active-low NMI line and latches a pending flag on a
// falling edge (sampled 1, then 0). A new edge wins over a clear in the
// same cycle so an NMI arriving exactly at vector fetch is not lost.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_nmi        NMI line (active low, synchronous to clk)
//   i_clr        clear the pending flag
//   o_edge       falling edge seen this cycle (combinational)
//   o_pending    registered pending flag
module nmi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_nmi,
  input  logic i_clr,
  output logic o_edge,
  output logic o_pending
);

  logic r_nmi_q;
  logic r_pending;

  assign o_edge    = r_nmi_q & ~i_nmi;
  assign o_pending = r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nmi_q   <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_nmi_q   <= i_nmi;
      r_pending <= o_edge | (r_pending & ~i_clr);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// Runs the seven-cycle 6502 entry flow for reset, NMI, BRK and IRQ:
// arbitration at the opcode-fetch (sync) cycle, one dummy read, three
// stack pushes (PCH, PCL, P), then the two vector reads into the PC.
// Reset runs the same flow with the push writes turned into reads.
// Parameter:
//   STACK_PAGE      high address byte of push cycles
// Ports:
//   clk, res        clock, async active-low reset
//   rdy             low stalls read cycles only
//   nmi, irq        active-low requests (NMI edge, IRQ level)
//   i_flag          status I bit (masks IRQ)
//   sync, brk_op    decoder opcode-fetch cycle / BRK opcode present
//   sp              current stack pointer
//   busy            sequence active, decoder holds
//   addr_override, addr, rw   bus control while overriding
//   push_sel, b_flag          data-out source and B bit for pushed P
//   sp_dec, pcl_load, pch_load, set_i, pc_inc_inhibit, ack   strobes
// Build option:
//   INT_NMI_HIJACK_EN  an NMI edge seen during the dummy/push cycles of an
//                      IRQ/BRK entry redirects the vector to FFFA.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        res,
  input  logic        rdy,
  input  logic        nmi,
  input  logic        irq,
  input  logic        i_flag,
  input  logic        sync,
  input  logic        brk_op,
  input  logic [7:0]  sp,
  output logic        busy,
  output logic        addr_override,
  output logic [15:0] addr,
  output logic        rw,
  output logic [1:0]  push_sel,
  output logic        b_flag,
  output logic        sp_dec,
  output logic        pcl_load,
  output logic        pch_load,
  output logic        set_i,
  output logic        pc_inc_inhibit,
  output logic        ack
);

  state_e      r_state, w_next;
  kind_e       r_kind;
  logic [15:0] r_vec;

  logic  w_nmi_edge, w_nmi_pending, w_nmi_req, w_irq_req;
  logic  w_win_valid, w_is_read, w_adv, w_nmi_clr, w_push;
  kind_e w_win;

  nmi_edge_detect u_nmi (
    .clk       (clk),
    .rst_n     (res),
    .i_nmi     (nmi),
    .i_clr     (w_nmi_clr),
    .o_edge    (w_nmi_edge),
    .o_pending (w_nmi_pending)
  );

  // A fresh edge in the sync cycle itself counts, so an NMI that falls
  // together with sync is taken immediately.
  assign w_nmi_req = w_nmi_pending | w_nmi_edge;
  assign w_irq_req = ~irq & ~i_flag;

  assign w_push = (r_state == S_PUSH_PCH) || (r_state == S_PUSH_PCL) ||
                  (r_state == S_PUSH_P);

  // Read cycles stall on rdy; reset pushes are reads, so they stall too.
  assign w_is_read = (r_state == S_DUMMY) || (r_state == S_VEC_LO) ||
                     (r_state == S_VEC_HI) || (w_push && (r_kind == K_RES));
  assign w_adv     = ~w_is_read | rdy;
  assign w_nmi_clr = (r_state == S_VEC_LO) && w_adv && (r_vec == VEC_NMI);

  always_comb begin
    w_win_valid = 1'b1;
    w_win       = K_IRQ;
    if (w_nmi_req)      w_win = K_NMI;
    else if (brk_op)    w_win = K_BRK;
    else if (w_irq_req) w_win = K_IRQ;
    else                w_win_valid = 1'b0;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= S_RESET_HOLD;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_kind <= K_RES;
      r_vec  <= VEC_RES;
    end else begin
      case (r_state)
        S_RESET_HOLD: begin
          r_kind <= K_RES;
          r_vec  <= VEC_RES;
        end
        S_IDLE: begin
          if (sync && w_win_valid) begin
            r_kind <= w_win;
            r_vec  <= kind_vec(w_win);
          end
        end
`ifdef INT_NMI_HIJACK_EN
        S_DUMMY, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
          // B bit keeps the original kind; only the vector moves.
          if (((r_kind == K_IRQ) || (r_kind == K_BRK)) && w_nmi_req)
            r_vec <= VEC_NMI;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    busy           = (r_state != S_IDLE);
    addr_override  = 1'b0;
    addr           = 16'h0000;
    rw             = 1'b1;
    push_sel       = PSEL_NONE;
    b_flag         = 1'b0;
    sp_dec         = 1'b0;
    pcl_load       = 1'b0;
    pch_load       = 1'b0;
    set_i          = 1'b0;
    pc_inc_inhibit = 1'b0;
    ack            = 1'b0;

    case (r_state)
      S_RESET_HOLD: w_next = S_DUMMY;
      S_IDLE: begin
        if (sync && w_win_valid) begin
          w_next         = S_DUMMY;
          pc_inc_inhibit = (w_win == K_NMI) || (w_win == K_IRQ);
        end
      end
      S_DUMMY: if (w_adv) w_next = S_PUSH_PCH;
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
        addr_override = 1'b1;
        addr          = {STACK_PAGE, sp};
        rw            = (r_kind == K_RES);
        b_flag        = (r_kind == K_BRK);
        // One decrement per completed push, even if a reset push stalls.
        sp_dec        = w_adv;
        case (r_state)
          S_PUSH_PCH: begin push_sel = PSEL_PCH; if (w_adv) w_next = S_PUSH_PCL; end
          S_PUSH_PCL: begin push_sel = PSEL_PCL; if (w_adv) w_next = S_PUSH_P;   end
          default:    begin push_sel = PSEL_P;   if (w_adv) w_next = S_VEC_LO;   end
        endcase
      end
      S_VEC_LO: begin
        addr_override = 1'b1;
        addr          = r_vec;
        pcl_load      = 1'b1;
        set_i         = 1'b1;
        if (w_adv) w_next = S_VEC_HI;
      end
      S_VEC_HI: begin
        addr_override = 1'b1;
        addr          = r_vec + 16'd1;
        pch_load      = 1'b1;
        ack           = 1'b1;
        if (w_adv) w_next = S_IDLE;
      end
      default: w_next = S_RESET_HOLD;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk, res, rdy, nmi, irq, i_flag, sync, brk_op;
  logic [7:0]  sp;
  logic        busy, addr_override, rw, b_flag, sp_dec;
  logic        pcl_load, pch_load, set_i, pc_inc_inhibit, ack;
  logic [15:0] addr;
  logic [1:0]  push_sel;
  logic [27:0] act_v;

  int n_chk  = 0;
  int n_pass = 0;
  bit model_en = 0;
  bit sp_dec_pend = 0;

  interrupt_sequencer dut (
    .clk(clk), .res(res), .rdy(rdy), .nmi(nmi), .irq(irq), .i_flag(i_flag),
    .sync(sync), .brk_op(brk_op), .sp(sp), .busy(busy),
    .addr_override(addr_override), .addr(addr), .rw(rw), .push_sel(push_sel),
    .b_flag(b_flag), .sp_dec(sp_dec), .pcl_load(pcl_load), .pch_load(pch_load),
    .set_i(set_i), .pc_inc_inhibit(pc_inc_inhibit), .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act_v = {busy, addr_override, addr, rw, push_sel, b_flag, sp_dec,
                  pcl_load, pch_load, set_i, pc_inc_inhibit, ack};

  function automatic logic [27:0] pk(input logic bz, input logic ov, input logic [15:0] ad,
                                     input logic w, input logic [1:0] ps, input logic bf,
                                     input logic sd, input logic pl, input logic ph,
                                     input logic si, input logic ih, input logic ak);
    return {bz, ov, ad, w, ps, bf, sd, pl, ph, si, ih, ak};
  endfunction

  task automatic chk(input string nm, input logic [27:0] a, input logic [27:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endtask

  // ---------------- reference model (transaction queue) ----------------
  typedef struct {
    logic [15:0] addr;
    bit ovr, rw, push, pcl, pch, rd, b;
    logic [1:0] psel;
  } ent_t;

  ent_t q[$];
  bit   m_prev_nmi, m_pend;
  int   m_kind, m_idx;   // kind: 1 NMI, 2 BRK, 3 IRQ

  task automatic build(input int k);
    ent_t e;
    logic [15:0] v;
    v = (k == 1) ? 16'hFFFA : 16'hFFFE;
    q.delete();
    e = '{addr:16'h0, ovr:0, rw:1, push:0, pcl:0, pch:0, rd:1, b:0, psel:2'd0};
    q.push_back(e);
    for (int i = 1; i <= 3; i++) begin
      e = '{addr:16'h0, ovr:1, rw:0, push:1, pcl:0, pch:0, rd:0, b:(k == 2), psel:2'(i)};
      q.push_back(e);
    end
    e = '{addr:v, ovr:1, rw:1, push:0, pcl:1, pch:0, rd:1, b:0, psel:2'd0};
    q.push_back(e);
    e = '{addr:v + 16'd1, ovr:1, rw:1, push:0, pcl:0, pch:1, rd:1, b:0, psel:2'd0};
    q.push_back(e);
    m_kind = k;
    m_idx  = 0;
  endtask

  task automatic model_step();
    bit edg, nreq, clr, adv, inh;
    int k;
    ent_t h;
    edg  = m_prev_nmi && !nmi;
    nreq = m_pend || edg;
    clr  = 0;
    if (q.size() == 0) begin
      inh = 0;
      if (sync) begin
        k = nreq ? 1 : brk_op ? 2 : (!irq && !i_flag) ? 3 : 0;
        inh = (k == 1) || (k == 3);
        if (k != 0) build(k);
      end
      chk("rand idle", act_v, pk(L, L, 16'h0, H, 2'd0, L, L, L, L, L, inh, L));
    end else begin
`ifdef INT_NMI_HIJACK_EN
      if ((m_kind == 2 || m_kind == 3) && m_idx <= 3 && nreq)
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].pcl) q[i].addr = 16'hFFFA;
          if (q[i].pch) q[i].addr = 16'hFFFB;
        end
`endif
      h   = q[0];
      adv = !h.rd || rdy;
      chk($sformatf("rand seq T%0d", m_idx + 1), act_v,
          pk(H, h.ovr, h.push ? {8'h01, sp} : h.addr, h.rw, h.psel, h.b,
             h.push && adv, h.pcl, h.pch, h.pcl, L, h.pch));
      if (adv) begin
        if (h.pcl && h.addr == 16'hFFFA) clr = 1;
        if (h.push) sp_dec_pend = 1;
        void'(q.pop_front());
        m_idx++;
      end
    end
    m_pend     = (m_pend && !clr) || edg;
    m_prev_nmi = nmi;
  endtask

  task automatic tick();
    if (model_en) model_step();
    @(negedge clk);
    if (sp_dec_pend) begin
      sp = sp - 8'd1;
      sp_dec_pend = 0;
    end
  endtask

  // Checks T1..T6 of one entry sequence; optional NMI edge, rdy stall
  // and reset abort at a given phase.
  task automatic run_seq(input string nm, input logic [15:0] vec, input logic b,
                         input logic isres, input int nmi_at, input int stall_at,
                         input int stall_n, input int abort_at);
    int j, st;
    logic [7:0] s0;
    logic [27:0] e;
    j = 1; st = 0; s0 = sp;
    while (j <= 6) begin
      if (j == nmi_at) nmi = 1'b0;
      if (j == abort_at) begin
        res = 1'b0;
        #1;
        chk({nm, " abort"}, act_v, pk(H, L, 16'h0, H, 2'd0, L, L, L, L, L, L, L));
        tick();
        nmi = 1'b1;
        return;
      end
      rdy = (j == stall_at && st < stall_n) ? 1'b0 : 1'b1;
      #1;
      case (j)
        1:       e = pk(H, L, 16'h0, H, 2'd0, L, L, L, L, L, L, L);
        2, 3, 4: e = pk(H, H, {8'h01, s0 - 8'(j - 2)}, isres, 2'(j - 1), b, H, L, L, L, L, L);
        5:       e = pk(H, H, vec, H, 2'd0, L, L, H, L, H, L, L);
        default: e = pk(H, H, vec + 16'd1, H, 2'd0, L, L, L, H, L, L, H);
      endcase
      chk($sformatf("%s T%0d", nm, j), act_v, e);
      tick();
      if (!rdy) st++;
      else begin
        if (j >= 2 && j <= 4) sp = sp - 8'd1;
        j++;
      end
    end
    rdy = 1'b1;
    nmi = 1'b1;
  endtask

  task automatic release_reset(input string nm);
    res = 1'b1;
    #1;
    chk({nm, " hold"}, act_v, pk(H, L, 16'h0, H, 2'd0, L, L, L, L, L, L, L));
    tick();
    run_seq(nm, 16'hFFFC, L, H, 0, 0, 0, 0);
  endtask

  task automatic take(input string nm, input logic ir, input logic inh);
    sync = 1'b1; irq = ir; i_flag = 1'b0;
    #1;
    chk({nm, " T0"}, act_v, pk(L, L, 16'h0, H, 2'd0, L, L, L, L, L, inh, L));
    tick();
    sync = 1'b0;
  endtask

  typedef struct {
    logic irq, ifl, brk, nf, inh, taken;
    logic [15:0] vec;
    logic b;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{irq:0, ifl:0, brk:0, nf:0, inh:1, taken:1, vec:16'hFFFE, b:0};
    tbl[1] = '{irq:0, ifl:1, brk:0, nf:0, inh:0, taken:0, vec:16'hFFFE, b:0};
    tbl[2] = '{irq:1, ifl:0, brk:1, nf:0, inh:0, taken:1, vec:16'hFFFE, b:1};
    tbl[3] = '{irq:0, ifl:0, brk:1, nf:0, inh:0, taken:1, vec:16'hFFFE, b:1};
    tbl[4] = '{irq:1, ifl:0, brk:0, nf:1, inh:1, taken:1, vec:16'hFFFA, b:0};
    tbl[5] = '{irq:1, ifl:0, brk:1, nf:1, inh:1, taken:1, vec:16'hFFFA, b:0};
    tbl[6] = '{irq:1, ifl:0, brk:0, nf:0, inh:0, taken:0, vec:16'hFFFE, b:0};
    tbl[7] = '{irq:0, ifl:0, brk:0, nf:1, inh:1, taken:1, vec:16'hFFFA, b:0};

    res = 1'b0; rdy = 1'b1; nmi = 1'b1; irq = 1'b1; i_flag = 1'b0;
    sync = 1'b0; brk_op = 1'b0; sp = 8'hFD;

    @(negedge clk);
    #1;
    chk("reset state", act_v, pk(H, L, 16'h0, H, 2'd0, L, L, L, L, L, L, L));
    tick();
    release_reset("reset");
    #1;
    chk("idle after reset", act_v, pk(L, L, 16'h0, H, 2'd0, L, L, L, L, L, L, L));
    tick();

    // IRQ entry, sp = F0
    sp = 8'hF0;
    take("irq", 1'b0, H);
    irq = 1'b1;
    run_seq("irq", 16'hFFFE, L, L, 0, 0, 0, 0);

    // arbitration table
    for (int i = 0; i < 8; i++) begin
      nmi = 1'b1; sync = 1'b0; sp = 8'hE0;
      #1;
      tick();
      sync = 1'b1; irq = tbl[i].irq; i_flag = tbl[i].ifl; brk_op = tbl[i].brk;
      nmi = ~tbl[i].nf;
      #1;
      chk($sformatf("tbl%0d T0", i), act_v,
          pk(L, L, 16'h0, H, 2'd0, L, L, L, L, L, tbl[i].inh, L));
      tick();
      sync = 1'b0; brk_op = 1'b0; irq = 1'b1; i_flag = 1'b0; nmi = 1'b1;
      if (tbl[i].taken) run_seq($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].b, L, 0, 0, 0, 0);
      else begin
        #1;
        chk($sformatf("tbl%0d none", i), act_v, pk(L, L, 16'h0, H, 2'd0, L, L, L, L, L, L, L));
        tick();
      end
    end

    // NMI and IRQ together: NMI first, IRQ at the following sync
    sp = 8'hC0;
    nmi = 1'b0;
    take("nmi+irq", 1'b0, H);
    nmi = 1'b1;
    run_seq("nmi+irq nmi", 16'hFFFA, L, L, 0, 0, 0, 0);
    take("nmi+irq irq", 1'b0, H);
    irq = 1'b1;
    run_seq("nmi+irq irq", 16'hFFFE, L, L, 0, 0, 0, 0);

    // NMI edge during PUSH_PCL of an IRQ
    take("hijack", 1'b0, H);
    irq = 1'b1;
`ifdef INT_NMI_HIJACK_EN
    run_seq("hijack", 16'hFFFA, L, L, 3, 0, 0, 0);
    take("hijack after", 1'b1, L);
    #1;
    chk("hijack none", act_v, pk(L, L, 16'h0, H, 2'd0, L, L, L, L, L, L, L));
    tick();
`else
    run_seq("hijack", 16'hFFFE, L, L, 3, 0, 0, 0);
    take("hijack after", 1'b1, H);
    run_seq("hijack nmi", 16'hFFFA, L, L, 0, 0, 0, 0);
`endif

    // rdy low for 3 cycles in VEC_LO
    take("stall", 1'b0, H);
    irq = 1'b1;
    run_seq("stall", 16'hFFFE, L, L, 0, 5, 3, 0);

    // reset during PUSH_P
    take("abort", 1'b0, H);
    irq = 1'b1;
    run_seq("abort", 16'hFFFE, L, L, 0, 0, 0, 4);
    release_reset("abort reset");

    // randomized phase against the queue model
    m_prev_nmi = nmi; m_pend = 0; q.delete(); model_en = 1;
    for (int c = 0; c < 2000; c++) begin
      sync   = (q.size() == 0) && ($urandom_range(0, 2) == 0);
      brk_op = sync && ($urandom_range(0, 3) == 0);
      irq    = ($urandom_range(0, 2) != 0);
      i_flag = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 19) == 0) nmi = ~nmi;
      rdy    = ($urandom_range(0, 4) != 0);
      if (q.size() == 0 && !sync && $urandom_range(0, 7) == 0) sp = 8'($urandom);
      #1;
      tick();
    end
    sync = 1'b0; rdy = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++) begin
      #1;
      tick();
    end
    model_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
